// File: rtl/vmm_pkg.sv
// Shared types and constants for the vmm_wbuf video memory.
// Holds the default geometry, the write-entry layout for that geometry,
// and the encoding of the per-cycle array slot owner.
package vmm_pkg;

  localparam int VMM_DW = 8;
  localparam int VMM_AW = 13;
  localparam int VMM_FL = 2;

  // One queued CPU write at the default geometry: {addr, data}.
  typedef struct packed {
    logic [VMM_AW-1:0] addr;
    logic [VMM_DW-1:0] data;
  } wentry_t;

  // Owner of the single array port in a given cycle, highest priority first:
  // video read, CPU readback, FIFO drain, nothing.
  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'd0,
    SLOT_VIDEO = 2'd1,
    SLOT_READ  = 2'd2,
    SLOT_DRAIN = 2'd3
  } slot_e;

endpackage

// File: rtl/vmm_fifo.sv
// Synchronous FIFO of 2^FL entries, W bits wide, with a combinational head.
// Ports: clk/rst (async active-high), push/wdat, pop/rdat (head), count.
// Caller must not push when full nor pop when empty; pointers wrap mod 2^FL.
module vmm_fifo #(
  parameter int FL = 2,
  parameter int W  = 21
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdat,
  input  logic          pop,
  output logic [W-1:0]  rdat,
  output logic [FL:0]   count
);

  localparam int FD = 1 << FL;

  logic [W-1:0]  mem_q [FD];
  logic [FL-1:0] wptr_q, rptr_q;
  logic [FL:0]   count_q, count_d;

  // Storage is not reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wdat;
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign rdat  = mem_q[rptr_q];
  assign count = count_q;

endmodule

// File: rtl/vmm_wbuf.sv
// Single-port DWx2^AW video memory: video reads win the port, posted CPU
// writes queue in a 2^FL FIFO and drain on cycles video leaves idle.
// Ports: clock/reset, cw_* (CPU write), vr_* (video read, 1-cycle latency),
// cr_* CPU readback only when VMM_READBACK_EN is defined.
module vmm_wbuf
  import vmm_pkg::*;
#(
  parameter int DW = VMM_DW,
  parameter int AW = VMM_AW,
  parameter int FL = VMM_FL
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cw_valid,
  output logic          cw_ready,
  input  logic [AW-1:0] cw_addr,
  input  logic [DW-1:0] cw_data,
  input  logic          vr_en,
  input  logic [AW-1:0] vr_addr,
  output logic [DW-1:0] vr_data,
  output logic          vr_valid
`ifdef VMM_READBACK_EN
  ,
  input  logic          cr_valid,
  output logic          cr_ready,
  input  logic [AW-1:0] cr_addr,
  output logic [DW-1:0] cr_data,
  output logic          cr_dvalid
`endif
);

  // Entry layout mirrors vmm_pkg::wentry_t, sized by this instance's widths.
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  ent_t        push_ent, head_ent;
  logic        push, pop;
  logic [FL:0] fifo_count;
  slot_e       slot;

  logic [DW-1:0] mem_q [1 << AW];
  logic [DW-1:0] vr_data_q;
  logic          vr_valid_q;

  // count never exceeds FD, so count < FD is simply "MSB clear".
  assign cw_ready = !fifo_count[FL];
  assign push     = cw_valid && cw_ready;
  assign push_ent = '{addr: cw_addr, data: cw_data};
  assign pop      = (slot == SLOT_DRAIN);

  vmm_fifo #(
    .FL (FL),
    .W  ($bits(ent_t))
  ) u_fifo (
    .clk   (clock),
    .rst   (reset),
    .push  (push),
    .wdat  (push_ent),
    .pop   (pop),
    .rdat  (head_ent),
    .count (fifo_count)
  );

`ifdef VMM_READBACK_EN
  logic [DW-1:0] cr_data_q;
  logic          cr_dvalid_q;

  // Readback only once the FIFO is empty, so it can never miss a posted write.
  // Gated by reset so the port reports not-ready while held in reset.
  assign cr_ready = !reset && !vr_en && (fifo_count == '0);
`endif

  // Slot arbiter: video > readback > drain.
  always_comb begin
    slot = SLOT_IDLE;
    if (vr_en) begin
      slot = SLOT_VIDEO;
`ifdef VMM_READBACK_EN
    end else if (cr_valid && cr_ready) begin
      slot = SLOT_READ;
`endif
    end else if (fifo_count != '0) begin
      slot = SLOT_DRAIN;
    end
  end

  // Array contents are not reset.
  always_ff @(posedge clock) begin
    if (slot == SLOT_DRAIN) mem_q[head_ent.addr] <= head_ent.data;
  end

  // Video read data holds its last value between requests.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vr_data_q  <= '0;
      vr_valid_q <= 1'b0;
    end else begin
      vr_valid_q <= (slot == SLOT_VIDEO);
      if (slot == SLOT_VIDEO) vr_data_q <= mem_q[vr_addr];
    end
  end

  assign vr_data  = vr_data_q;
  assign vr_valid = vr_valid_q;

`ifdef VMM_READBACK_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cr_data_q   <= '0;
      cr_dvalid_q <= 1'b0;
    end else begin
      cr_dvalid_q <= (slot == SLOT_READ);
      if (slot == SLOT_READ) cr_data_q <= mem_q[cr_addr];
    end
  end

  assign cr_data   = cr_data_q;
  assign cr_dvalid = cr_dvalid_q;
`endif

endmodule
